// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes,
// controller states, iteration count and the sign fix-up record.
package muldiv_pkg;

    localparam int MULDIV_ITER = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

    // What the FIX step must do to the unsigned magnitude result.
    typedef struct packed {
        logic is_div;   // result layout: quotient/remainder vs 64-bit product
        logic neg_lo;   // negate product (mul) or quotient (div)
        logic neg_hi;   // negate remainder (div only)
    } fix_t;

endpackage

// File: rtl/muldiv_seq_core.sv
// Iterative datapath: radix-2 shift-add multiply and restoring
// shift-subtract divide over a shared 64-bit accumulator, plus the
// step counter. Operands are unsigned magnitudes; sign handling lives
// in the parent.
module muldiv_seq_core
    import muldiv_pkg::*;
#(
    parameter int ITER = MULDIV_ITER
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic        div_in,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [63:0] acc,
    output logic        last
);

    localparam int CW = $clog2(ITER);

    logic [CW-1:0] cnt;
    logic [31:0]   opb;
    logic          div_mode;
    logic [63:0]   acc_nxt;

    // Multiply: add multiplicand into the upper half when the current
    // multiplier bit (acc[0]) is set, then shift the whole thing right.
    logic [32:0] mul_sum;
    logic [63:0] mul_nxt;
    // Divide: {rem, dividend} shifts left one bit; subtract the divisor
    // when it fits and shift a quotient bit into the bottom.
    logic [32:0] div_sh;
    logic [31:0] div_rem;
    logic [63:0] div_nxt;

    // One iteration of whichever algorithm is loaded
    always_comb begin
        mul_sum = {1'b0, acc[63:32]} + {1'b0, opb};
        mul_nxt = acc[0] ? {mul_sum, acc[31:1]} : {1'b0, acc[63:32], acc[31:1]};
        div_sh  = acc[63:31];
        div_rem = div_sh[31:0] - opb;  // true difference always fits 32 bits
        if (div_sh >= {1'b0, opb})
            div_nxt = {div_rem, acc[30:0], 1'b1};
        else
            div_nxt = {div_sh[31:0], acc[30:0], 1'b0};
        acc_nxt = div_mode ? div_nxt : mul_nxt;
    end

    assign last = (cnt == '0);

    // Load operands on accept, then advance one step per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            opb      <= '0;
            cnt      <= '0;
            div_mode <= 1'b0;
        end else if (load) begin
            acc      <= {32'd0, op_a};
            opb      <= op_b;
            cnt      <= CW'(ITER - 1);
            div_mode <= div_in;
        end else if (step) begin
            acc <= acc_nxt;
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/muldiv_hilo.sv
// MIPS multiply/divide unit with the HI/LO register pair. Owns the
// accept logic, IDLE/RUN/FIX controller, sign fix-up and HI/LO.
// Optional build macro: MULDIV_FAST_MULT_EN -- single-cycle MULT/MULTU;
// division stays iterative either way.
module muldiv_hilo
    import muldiv_pkg::*;
#(
    parameter int ITER = MULDIV_ITER
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_e      state;
    fix_t        fix;
    logic        accept, is_mul, is_div, is_sgn, rt_zero, iter_go;
    logic [31:0] a_mag, b_mag;
    logic [63:0] core_acc, mul_res;
    logic [31:0] q_res, r_res;
    logic        core_last;

    assign busy    = (state != IDLE);
    assign accept  = start && (state == IDLE);
    assign is_mul  = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div  = (op == OP_DIV)  || (op == OP_DIVU);
    assign is_sgn  = (op == OP_MULT) || (op == OP_DIV);
    assign rt_zero = (rt_data == 32'd0);
    // -0x80000000 wraps to itself, which is the correct unsigned magnitude
    assign a_mag   = (is_sgn && rs_data[31]) ? -rs_data : rs_data;
    assign b_mag   = (is_sgn && rt_data[31]) ? -rt_data : rt_data;

`ifdef MULDIV_FAST_MULT_EN
    logic [63:0] fast_prod;
    // Low 64 bits of the sign-extended product equal the signed product
    assign fast_prod = {{32{is_sgn & rs_data[31]}}, rs_data} *
                       {{32{is_sgn & rt_data[31]}}, rt_data};
    assign iter_go   = accept && is_div && !rt_zero;
`else
    assign iter_go   = accept && (is_mul || (is_div && !rt_zero));
`endif

    muldiv_seq_core #(.ITER(ITER)) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (iter_go),
        .step   (state == RUN),
        .div_in (is_div),
        .op_a   (a_mag),
        .op_b   (b_mag),
        .acc    (core_acc),
        .last   (core_last)
    );

    assign mul_res = fix.neg_lo ? -core_acc : core_acc;
    assign q_res   = fix.neg_lo ? -core_acc[31:0]  : core_acc[31:0];
    assign r_res   = fix.neg_hi ? -core_acc[63:32] : core_acc[63:32];

    // Controller: accept, iterate, sign fix-up and HI/LO writeback
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fix      <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (op == OP_MTHI) begin
                            hi <= rs_data;
                        end else if (op == OP_MTLO) begin
                            lo <= rs_data;
                        end else if (is_div && rt_zero) begin
                            done     <= 1'b1;
                            div_zero <= 1'b1;
`ifdef MULDIV_FAST_MULT_EN
                        end else if (is_mul) begin
                            hi   <= fast_prod[63:32];
                            lo   <= fast_prod[31:0];
                            done <= 1'b1;
`endif
                        end else if (is_mul || is_div) begin
                            state      <= RUN;
                            fix.is_div <= is_div;
                            fix.neg_lo <= is_sgn && (rs_data[31] ^ rt_data[31]);
                            fix.neg_hi <= is_sgn && is_div && rs_data[31];
                        end
                    end
                end
                RUN: begin
                    if (core_last) state <= FIX;
                end
                FIX: begin
                    if (fix.is_div) begin
                        lo <= q_res;
                        hi <= r_res;
                    end else begin
                        hi <= mul_res[63:32];
                        lo <= mul_res[31:0];
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_hilo.sv
// Self-checking bench for muldiv_hilo: constant vector table, hand-written
// corner sequences and random ops against an arithmetic reference model.
module tb_muldiv_hilo;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_data = '0, rt_data = '0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int failures = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    muldiv_hilo dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
        string       nm;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Architectural result of one op: lat = edges after accept until the
    // edge that raises done (-1 = never raises done).
    function automatic void model(input logic [2:0] o, input logic [31:0] a, b,
                                  input logic [31:0] hi_i, lo_i,
                                  output logic [31:0] hi_o, lo_o,
                                  output bit dz, output int lat);
        longint sp, sq, sr;
        logic [63:0] up;
        hi_o = hi_i; lo_o = lo_i; dz = 0; lat = -1;
        case (o)
            3'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                hi_o = sp[63:32]; lo_o = sp[31:0];
`ifdef MULDIV_FAST_MULT_EN
                lat = 0;
`else
                lat = MULDIV_ITER + 1;
`endif
            end
            3'd1: begin
                up = {32'd0, a} * {32'd0, b};
                hi_o = up[63:32]; lo_o = up[31:0];
`ifdef MULDIV_FAST_MULT_EN
                lat = 0;
`else
                lat = MULDIV_ITER + 1;
`endif
            end
            3'd2, 3'd3: begin
                if (b == 0) begin
                    dz = 1; lat = 0;
                end else begin
                    lat = MULDIV_ITER + 1;
                    if (o == 3'd2) begin
                        sq = longint'($signed(a)) / longint'($signed(b));
                        sr = longint'($signed(a)) % longint'($signed(b));
                        lo_o = sq[31:0]; hi_o = sr[31:0];
                    end else begin
                        lo_o = a / b; hi_o = a % b;
                    end
                end
            end
            3'd4: hi_o = a;
            3'd5: lo_o = a;
            default: ;
        endcase
    endfunction

    // Issue one op (called just after an edge) and check it to completion.
    task automatic exec(input logic [2:0] o, input logic [31:0] a, b,
                        input string nm, input bit inj);
        logic [31:0] eh, el;
        bit edz;
        int lat, k;
        model(o, a, b, m_hi, m_lo, eh, el, edz, lat);
        start = 1; op = o; rs_data = a; rt_data = b;
        @(posedge clk); #1;
        start = 0;
        if (lat < 0) begin
            chk({nm, "_done"}, 64'(done), 64'(0));
            chk({nm, "_busy"}, 64'(busy), 64'(0));
        end else begin
            k = 0;
            while (!done && k < 100) begin
                if (k == 20) chk({nm, "_hold_hi"}, 64'(hi), 64'(m_hi));
                if (inj && k == 10) begin
                    start = 1; op = OP_MTHI; rs_data = 32'h1234;
                end
                @(posedge clk); #1;
                start = 0;
                k++;
            end
            chk({nm, "_lat"}, 64'(k), 64'(lat));
            chk({nm, "_dz"}, 64'(div_zero), 64'(edz));
            chk({nm, "_busy"}, 64'(busy), 64'(0));
        end
        chk({nm, "_hi"}, 64'(hi), 64'(eh));
        chk({nm, "_lo"}, 64'(lo), 64'(el));
        m_hi = eh; m_lo = el;
    endtask

    initial begin
        vec_t tbl[8];
        logic [31:0] ra, rb;
        logic [2:0]  ro;

        tbl[0] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"};
        tbl[1] = '{3'd0, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg"};
        tbl[2] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_min"};
        tbl[3] = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg"};
        tbl[4] = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14,       "divu_100_7"};
        tbl[5] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf"};
        tbl[6] = '{3'd1, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, "multu_shift"};
        tbl[7] = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_negdivisor"};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_dz", 64'(div_zero), 64'(0));
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;

        // Constant vectors, issued back to back (next start in the done cycle)
        for (int i = 0; i < 8; i++) begin
            exec(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].nm, 0);
            chk({tbl[i].nm, "_tbl_hi"}, 64'(hi), 64'(tbl[i].hi));
            chk({tbl[i].nm, "_tbl_lo"}, 64'(lo), 64'(tbl[i].lo));
        end

        // Divide by zero leaves preloaded HI/LO untouched
        exec(OP_MTHI, 32'hAA, 32'd0, "mthi_aa", 0);
        exec(OP_MTLO, 32'hBB, 32'd0, "mtlo_bb", 0);
        exec(OP_DIVU, 32'd5, 32'd0, "divu_zero", 0);
        chk("divu_zero_hi_const", 64'(hi), 64'(32'hAA));
        chk("divu_zero_lo_const", 64'(lo), 64'(32'hBB));
        @(posedge clk); #1;
        chk("divu_zero_pulse", 64'(done), 64'(0));

        // MTHI while a DIV is running must be dropped
        exec(OP_DIV, 32'd1000, 32'd33, "div_inject", 1);
        chk("div_inject_rem", 64'(hi), 64'(32'd10));

        // Unused op codes do nothing
        exec(3'd6, 32'h5555, 32'h1, "op6", 0);
        exec(3'd7, 32'h6666, 32'h1, "op7", 0);

        // Random ops against the model
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 :
                 ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            exec(ro, ra, rb, "rand", 0);
        end

        // Reset in the middle of a MULTU
        start = 1; op = OP_MULTU; rs_data = 32'hDEADBEEF; rt_data = 32'h12345;
        @(posedge clk); #1;
        start = 0;
        repeat (14) @(posedge clk);
        #1;
        chk("midrst_busy_before", 64'(busy), 64'(1));
        #2 rst_n = 0;
        #1;
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_hi", 64'(hi), 64'(0));
        chk("midrst_lo", 64'(lo), 64'(0));
        chk("midrst_done", 64'(done), 64'(0));
        m_hi = '0; m_lo = '0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        exec(OP_DIVU, 32'd9, 32'd3, "post_rst_divu", 0);
        chk("post_rst_lo_const", 64'(lo), 64'(32'd3));
        chk("post_rst_hi_const", 64'(hi), 64'(32'd0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
